triangle_stream_tx: RTL and testbench

TRIANGLE_STREAM_TX -- requirements
Module: triangle_stream_tx

---
 rtl/triangle_stream_pkg.sv | 22 ++
 rtl/triangle_stream_tx.sv | 153 +++++++++++++++
 tb/tb_triangle_stream_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_stream_pkg.sv
// rtl/triangle_stream_pkg.sv - geometry and color types shared by the triangle stream transmitter
package triangle_stream_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } Point3D;

  typedef struct packed {
    Point3D p;
    Point3D q;
    Point3D r;
  } Triangle3D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

endpackage

// File: rtl/triangle_stream_tx.sv
// rtl/triangle_stream_tx.sv - frames triangles into a six-word stream bracketed by start/end marker words
module triangle_stream_tx
  import triangle_stream_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        frame_start_req,
  input  logic        frame_end_req,
  input  Triangle3D   triangle,
  input  Color        color,
  input  logic        tri_valid,
  output logic        tri_accept,
  output logic        busy,
  output logic [31:0] ahb_buffer,
  output logic        ahb_data_available,
  input  logic        ahb_user_read_buffer,
  output logic [15:0] tri_sent_count
);

  typedef enum logic [2:0] {IDLE, START, FRAME, SEND, END} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] words_q [6];
  logic [31:0] words_d [6];
  logic [31:0] buffer_q, buffer_d;
  logic        avail_q, avail_d;
  logic        accept_q, accept_d;
  logic        busy_q, busy_d;
  logic [15:0] count_q, count_d;
  logic        end_pend_q, end_pend_d;

  logic       xfer;
  logic [2:0] idx_next;

  assign xfer     = avail_q & ahb_user_read_buffer;
  assign idx_next = idx_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      buffer_q   <= 32'h0;
      avail_q    <= 1'b0;
      accept_q   <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= 16'h0;
      end_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buffer_q   <= buffer_d;
      avail_q    <= avail_d;
      accept_q   <= accept_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
      end_pend_q <= end_pend_d;
    end
  end

  // Captured words are pure datapath; validity is tracked by the FSM alone.
  always_ff @(posedge clk) begin
    words_q <= words_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start_req) state_d = START;
      START:   if (xfer) state_d = FRAME;
      FRAME: begin
        if (tri_valid)                         state_d = SEND;
        else if (end_pend_q || frame_end_req)  state_d = END;
      end
      SEND:    if (xfer && idx_q == 3'd5) state_d = FRAME;
      END:     if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    words_d    = words_q;
    buffer_d   = buffer_q;
    avail_d    = avail_q;
    accept_d   = 1'b0;
    count_d    = count_q;
    end_pend_d = end_pend_q;
    busy_d     = (state_d != IDLE);

    // A late end request is parked so the END word can never split a triangle.
    if (state_q != IDLE && frame_end_req) end_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_start_req) begin
          buffer_d = 32'h0000_0000;
          avail_d  = 1'b1;
        end
      end
      START: begin
        if (xfer) begin
          avail_d = 1'b0;
          count_d = 16'h0;
        end
      end
      FRAME: begin
        if (tri_valid) begin
          words_d[0] = {triangle.p.y, triangle.p.x};
          words_d[1] = {triangle.q.x, triangle.p.z};
          words_d[2] = {triangle.q.z, triangle.q.y};
          words_d[3] = {triangle.r.y, triangle.r.x};
          words_d[4] = {color.g, color.r, triangle.r.z};
          words_d[5] = {24'h0, color.b};
          buffer_d   = {triangle.p.y, triangle.p.x};
          avail_d    = 1'b1;
          accept_d   = 1'b1;
          idx_d      = 3'd0;
        end else if (end_pend_q || frame_end_req) begin
          buffer_d = 32'h0000_0001;
          avail_d  = 1'b1;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == 3'd5) begin
            avail_d = 1'b0;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          end else begin
            idx_d    = idx_next;
            buffer_d = words_q[idx_next];
          end
        end
      end
      END: begin
        if (xfer) begin
          avail_d    = 1'b0;
          end_pend_d = 1'b0;
        end
      end
      default: begin
        avail_d = 1'b0;
      end
    endcase
  end

  assign tri_accept         = accept_q;
  assign busy               = busy_q;
  assign ahb_buffer         = buffer_q;
  assign ahb_data_available = avail_q;
  assign tri_sent_count     = count_q;

endmodule

// File: tb/tb_triangle_stream_tx.sv
// tb/tb_triangle_stream_tx.sv - directed table-driven bench for triangle_stream_tx
module tb_triangle_stream_tx;
  import triangle_stream_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        frame_start_req;
  logic        frame_end_req;
  Triangle3D   triangle;
  Color        color;
  logic        tri_valid;
  logic        tri_accept;
  logic        busy;
  logic [31:0] ahb_buffer;
  logic        ahb_data_available;
  logic        ahb_user_read_buffer;
  logic [15:0] tri_sent_count;

  triangle_stream_tx dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .frame_start_req      (frame_start_req),
    .frame_end_req        (frame_end_req),
    .triangle             (triangle),
    .color                (color),
    .tri_valid            (tri_valid),
    .tri_accept           (tri_accept),
    .busy                 (busy),
    .ahb_buffer           (ahb_buffer),
    .ahb_data_available   (ahb_data_available),
    .ahb_user_read_buffer (ahb_user_read_buffer),
    .tri_sent_count       (tri_sent_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    Triangle3D         t;
    Color              c;
    logic [5:0][31:0]  w;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] rx [$];
  int          rx_cyc [$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  int          hold_err = 0;
  bit          bp_en = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_buf = 32'h0;

  // Transfers are recorded half a cycle before the edge that performs them.
  always @(negedge clk) begin
    if (prev_hold && (ahb_buffer !== prev_buf || ahb_data_available !== 1'b1)) hold_err++;
    prev_hold = n_rst && ahb_data_available && !ahb_user_read_buffer;
    prev_buf  = ahb_buffer;
    if (n_rst && ahb_data_available && ahb_user_read_buffer) begin
      rx.push_back(ahb_buffer);
      rx_cyc.push_back(cyc);
    end
    if (n_rst && tri_accept) acc_cnt++;
  end

  function automatic Triangle3D mk_tri(input logic [15:0] px, py, pz, qx, qy, qz, rx_, ry, rz);
    Triangle3D t;
    t.p.x = px; t.p.y = py; t.p.z = pz;
    t.q.x = qx; t.q.y = qy; t.q.z = qz;
    t.r.x = rx_; t.r.y = ry; t.r.z = rz;
    return t;
  endfunction

  function automatic vec_t mk_vec(input Triangle3D t, input logic [7:0] cr, cg, cb,
                                  input logic [31:0] w0, w1, w2, w3, w4, w5);
    vec_t v;
    v.t = t;
    v.c.r = cr; v.c.g = cg; v.c.b = cb;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bp_en) ahb_user_read_buffer = (cyc % 3 == 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic scramble();
    logic [159:0] rnd;
    rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    triangle = rnd[143:0];
    color    = rnd[159:136];
  endtask

  task automatic wait_words(input int n, input string nm);
    int k = 0;
    while (rx.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk({nm, "_word_timeout"}, 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    chk({nm, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_start();
    frame_start_req = 1'b1;
    tick();
    frame_start_req = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end_req = 1'b1;
    tick();
    frame_end_req = 1'b0;
  endtask

  task automatic send_tri(input vec_t v, input bit with_end, input string nm);
    int k = 0;
    triangle      = v.t;
    color         = v.c;
    tri_valid     = 1'b1;
    frame_end_req = with_end;
    do begin
      tick();
      k++;
    end while (!tri_accept && k < 50);
    chk({nm, "_accept"}, 32'(tri_accept), 32'd1);
    chk({nm, "_lat_avail"}, 32'(ahb_data_available), 32'd1);
    chk({nm, "_lat_w0"}, ahb_buffer, v.w[0]);
    tri_valid     = 1'b0;
    frame_end_req = 1'b0;
    scramble();
  endtask

  task automatic chk_tri(input string nm, input int base, input vec_t v);
    for (int j = 0; j < 6; j++) chk($sformatf("%s_w%0d", nm, j), rx[base + j], v.w[j]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk_vec(mk_tri(160, 190, 50, 40, 239, 30, 280, 239, 30), 8'd255, 8'd0, 8'd0,
                     32'h00BE00A0, 32'h00280032, 32'h001E00EF, 32'h00EF0118, 32'h00FF001E, 32'h00000000);
    vecs[1] = mk_vec(mk_tri(1, 2, 3, 4, 5, 6, 7, 8, 9), 8'h11, 8'h22, 8'h33,
                     32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007, 32'h22110009, 32'h00000033);
    vecs[2] = mk_vec(mk_tri(16'hFFFF, 16'h8000, 16'h1234, 16'hABCD, 16'h0000, 16'h7FFF,
                            16'hDEAD, 16'hBEEF, 16'hCAFE), 8'hA5, 8'h5A, 8'hFF,
                     32'h8000FFFF, 32'hABCD1234, 32'h7FFF0000, 32'hBEEFDEAD, 32'h5AA5CAFE, 32'h000000FF);
    vecs[3] = mk_vec(mk_tri(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600,
                            16'h0700, 16'h0800, 16'h0900), 8'h01, 8'h02, 8'h03,
                     32'h02000100, 32'h04000300, 32'h06000500, 32'h08000700, 32'h02010900, 32'h00000003);

    n_rst = 1'b0;
    frame_start_req = 1'b0;
    frame_end_req = 1'b0;
    tri_valid = 1'b0;
    ahb_user_read_buffer = 1'b1;
    scramble();
    repeat (3) tick();
    chk("rst_buffer", ahb_buffer, 32'h0);
    chk("rst_avail", 32'(ahb_data_available), 32'd0);
    chk("rst_accept", 32'(tri_accept), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(tri_sent_count), 32'd0);
    n_rst = 1'b1;
    tick();

    // Requests other than start are ignored in IDLE
    tri_valid = 1'b1;
    frame_end_req = 1'b1;
    repeat (3) tick();
    tri_valid = 1'b0;
    frame_end_req = 1'b0;
    tick();
    chk("idle_no_accept", 32'(acc_cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_no_words", 32'(rx.size()), 32'd0);

    // Empty frame; end requested while START word is pending
    rx.delete(); rx_cyc.delete();
    pulse_start();
    chk("empty_busy", 32'(busy), 32'd1);
    pulse_end();
    wait_idle("empty");
    chk("empty_nwords", 32'(rx.size()), 32'd2);
    chk("empty_w0", rx[0], 32'h0);
    chk("empty_w1", rx[1], 32'h1);
    chk("empty_count", 32'(tri_sent_count), 32'd0);

    // Four table triangles back to back, then end
    rx.delete(); rx_cyc.delete(); acc_cnt = 0;
    pulse_start();
    wait_words(1, "b2b_start");
    for (int i = 0; i < 4; i++) begin
      if (i == 1) pulse_start();
      send_tri(vecs[i], 1'b0, $sformatf("b2b%0d", i));
      wait_words(1 + 6 * (i + 1), $sformatf("b2b%0d", i));
      chk_tri($sformatf("b2b%0d", i), 1 + 6 * i, vecs[i]);
      chk($sformatf("b2b%0d_nobubble", i), 32'(rx_cyc[6 * i + 6] - rx_cyc[6 * i + 1]), 32'd5);
      chk($sformatf("b2b%0d_count", i), 32'(tri_sent_count), 32'(i + 1));
    end
    pulse_end();
    wait_idle("b2b");
    chk("b2b_first", rx[0], 32'h0);
    chk("b2b_nwords", 32'(rx.size()), 32'd26);
    chk("b2b_last", rx[25], 32'h1);
    chk("b2b_accepts", 32'(acc_cnt), 32'd4);
    chk("b2b_count", 32'(tri_sent_count), 32'd4);

    // Backpressure: read pattern 1,0,0 repeating
    rx.delete(); rx_cyc.delete(); hold_err = 0; bp_en = 1;
    pulse_start();
    wait_words(1, "bp_start");
    chk("bp_count_clear", 32'(tri_sent_count), 32'd0);
    send_tri(vecs[1], 1'b0, "bp");
    wait_words(7, "bp");
    pulse_end();
    wait_idle("bp");
    bp_en = 0;
    ahb_user_read_buffer = 1'b1;
    chk("bp_nwords", 32'(rx.size()), 32'd8);
    chk("bp_first", rx[0], 32'h0);
    chk_tri("bp", 1, vecs[1]);
    chk("bp_last", rx[7], 32'h1);
    chk("bp_hold", 32'(hold_err), 32'd0);

    // End request during the w2 transfer
    rx.delete(); rx_cyc.delete();
    pulse_start();
    wait_words(1, "mid_start");
    send_tri(vecs[2], 1'b0, "mid");
    for (int k = 0; k < 20 && !(ahb_data_available && ahb_buffer == vecs[2].w[2]); k++) tick();
    chk("mid_found_w2", ahb_buffer, vecs[2].w[2]);
    pulse_end();
    wait_idle("mid");
    chk("mid_nwords", 32'(rx.size()), 32'd8);
    chk_tri("mid", 1, vecs[2]);
    chk("mid_last", rx[7], 32'h1);
    chk("mid_count", 32'(tri_sent_count), 32'd1);

    // tri_valid and frame_end_req together in FRAME
    rx.delete(); rx_cyc.delete();
    pulse_start();
    wait_words(1, "both_start");
    send_tri(vecs[3], 1'b1, "both");
    wait_idle("both");
    chk("both_nwords", 32'(rx.size()), 32'd8);
    chk_tri("both", 1, vecs[3]);
    chk("both_last", rx[7], 32'h1);
    chk("both_count", 32'(tri_sent_count), 32'd1);

    // Reset right after w3 has transferred
    rx.delete(); rx_cyc.delete();
    pulse_start();
    wait_words(1, "rst_start");
    send_tri(vecs[0], 1'b0, "midrst");
    wait_words(5, "midrst");
    n_rst = 1'b0;
    tick();
    chk("midrst_avail", 32'(ahb_data_available), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(tri_sent_count), 32'd0);
    n_rst = 1'b1;
    repeat (5) tick();
    chk("midrst_no_more", 32'(rx.size()), 32'd5);
    rx.delete(); rx_cyc.delete();
    pulse_start();
    wait_words(1, "restart");
    chk("restart_w0", rx[0], 32'h0);
    pulse_end();
    wait_idle("restart");
    chk("restart_last", rx[rx.size() - 1], 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
